// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the single-bus CPU datapath: fetch, decode and
// execute with a bounded memory-read handshake; HALT and ERROR are sticky until reset.
module cpu_control_fsm #(
  parameter logic [1:0] FN_PASS  = 2'b00,
  parameter logic [1:0] FN_INC   = 2'b11,
  parameter int         MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instruction,
  input  logic        status,
  input  logic        mem_ready,
  output logic        ld_ir,
  output logic        t_ir,
  output logic        ld_mar,
  output logic        t_mar,
  output logic        ld_mdr,
  output logic        t_mdr,
  output logic        ld_sp,
  output logic        t_sp,
  output logic        ld_pc,
  output logic        t_pc,
  output logic        ld_reg,
  output logic        t_reg,
  output logic        ld_y,
  output logic        t_y,
  output logic        selector,
  output logic [1:0]  controller_fn,
  output logic        mem_rd,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal_op
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVY = 4'h1;
  localparam logic [3:0] OP_ALU  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_LDSP = 4'h4;
  localparam logic [3:0] OP_JMPC = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_MOVY, S_ALU, S_LDSP, S_JMP, S_SKIP,
    S_LDI0, S_LDI1, S_LDI2, S_LDI3,
    S_HALT, S_ERROR
  } state_t;

  typedef struct packed {
    logic       ld_ir, t_ir, ld_mar, t_mar, t_mdr, ld_sp, t_sp;
    logic       ld_pc, t_pc, ld_reg, t_reg, ld_y, t_y, selector;
    logic [1:0] fn;
    logic       mem_rd, halted, bus_err, illegal_op;
  } ctl_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [3:0] opcode;
  logic       in_memwait;
  ctl_t       ctl;

  assign opcode     = instruction[15:12];
  assign in_memwait = (state == S_FETCH1) || (state == S_LDI1);

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic unused_instr;
  assign unused_instr = ^instruction[11:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_FETCH0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_FETCH0: begin
          state    <= S_FETCH1;
          wait_cnt <= '0;
        end
        S_FETCH1: begin
          if (mem_ready)               state    <= S_FETCH2;
          else if (wait_cnt == MAX_CNT) state    <= S_ERROR;
          else                         wait_cnt <= wait_cnt + 8'd1;
        end
        S_FETCH2: state <= S_FETCH3;
        S_FETCH3: state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_MOVY: state <= S_MOVY;
            OP_ALU:  state <= S_ALU;
            OP_LDI:  state <= S_LDI0;
            OP_LDSP: state <= S_LDSP;
            OP_JMPC: state <= status ? S_JMP : S_SKIP;
            OP_HALT: state <= S_HALT;
            default: state <= S_FETCH0;
          endcase
        end
        S_LDI0: begin
          state    <= S_LDI1;
          wait_cnt <= '0;
        end
        S_LDI1: begin
          if (mem_ready)               state    <= S_LDI2;
          else if (wait_cnt == MAX_CNT) state    <= S_ERROR;
          else                         wait_cnt <= wait_cnt + 8'd1;
        end
        S_LDI2: state <= S_LDI3;
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: state <= S_FETCH0;
      endcase
    end
  end

  // Moore decode; the reset cycle forces everything low regardless of the old state.
  always_comb begin
    ctl = '0;
    if (reset_n) begin
      case (state)
        S_FETCH0, S_LDI0: begin
          ctl.t_pc   = 1'b1;
          ctl.fn     = FN_PASS;
          ctl.ld_mar = 1'b1;
        end
        S_FETCH1, S_LDI1: ctl.mem_rd = 1'b1;
        S_FETCH2: begin
          ctl.t_mdr = 1'b1;
          ctl.fn    = FN_PASS;
          ctl.ld_ir = 1'b1;
        end
        S_LDI2: begin
          ctl.t_mdr  = 1'b1;
          ctl.fn     = FN_PASS;
          ctl.ld_reg = 1'b1;
        end
        S_FETCH3, S_LDI3: begin
          ctl.t_pc  = 1'b1;
          ctl.fn    = FN_INC;
          ctl.ld_pc = 1'b1;
        end
        S_DECODE: ctl.illegal_op = !(opcode <= OP_JMPC || opcode == OP_HALT);
        S_MOVY: begin
          ctl.t_reg = 1'b1;
          ctl.ld_y  = 1'b1;
        end
        S_ALU: begin
          ctl.t_reg    = 1'b1;
          ctl.selector = 1'b1;
          ctl.ld_reg   = 1'b1;
        end
        S_LDSP: begin
          ctl.t_reg = 1'b1;
          ctl.fn    = FN_PASS;
          ctl.ld_sp = 1'b1;
        end
        S_JMP: begin
          ctl.t_reg = 1'b1;
          ctl.fn    = FN_PASS;
          ctl.ld_pc = 1'b1;
        end
        S_HALT:  ctl.halted  = 1'b1;
        S_ERROR: ctl.bus_err = 1'b1;
        default: ctl = '0;
      endcase
    end
  end

  assign ld_ir         = ctl.ld_ir;
  assign t_ir          = ctl.t_ir;
  assign ld_mar        = ctl.ld_mar;
  assign t_mar         = ctl.t_mar;
  assign ld_mdr        = reset_n && in_memwait && mem_ready;
  assign t_mdr         = ctl.t_mdr;
  assign ld_sp         = ctl.ld_sp;
  assign t_sp          = ctl.t_sp;
  assign ld_pc         = ctl.ld_pc;
  assign t_pc          = ctl.t_pc;
  assign ld_reg        = ctl.ld_reg;
  assign t_reg         = ctl.t_reg;
  assign ld_y          = ctl.ld_y;
  assign t_y           = ctl.t_y;
  assign selector      = ctl.selector;
  assign controller_fn = ctl.fn;
  assign mem_rd        = ctl.mem_rd;
  assign halted        = ctl.halted;
  assign bus_err       = ctl.bus_err;
  assign illegal_op    = ctl.illegal_op;

endmodule
